// File: rtl/mult_pkg.sv
// ============================================================================
// Module  : mult_pkg
// Brief   : Shared FSM state encoding and step-counter width for the
//           iterative multiplier.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    // Step counter width does not depend on WIDTH. It covers every legal WIDTH up to 64.
    localparam int c_STEP_W = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/twos_magnitude.sv
// ============================================================================
// Module  : twos_magnitude
// Brief   : Unsigned magnitude of an operand that is optionally two's-complement.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module twos_magnitude #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic [WIDTH-1:0] magnitude
);

    // The result is unsigned, so the most negative input maps to 2^(WIDTH-1).
    assign magnitude = (is_signed && value[WIDTH-1]) ? (~value + WIDTH'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/multiplier_iterative_param.sv
// ============================================================================
// Module  : multiplier_iterative_param
// Brief   : Shift-and-add sign-magnitude multiplier with optional early exit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multiplier_iterative_param
    import mult_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic                 signed_in,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready_out,
    output logic                 valid_out,
    output logic [2*WIDTH-1:0]   r
);

    state_t                r_state;
    logic [WIDTH-1:0]      r_mp;
    logic [2*WIDTH-1:0]    r_mc;
    logic [2*WIDTH-1:0]    r_acc;
    logic [c_STEP_W-1:0]   r_step;
    logic                  r_neg;
    logic [2*WIDTH-1:0]    r_result;
    logic                  r_valid;

    logic [WIDTH-1:0]      w_mag_a;
    logic [WIDTH-1:0]      w_mag_b;
    logic [2*WIDTH-1:0]    w_acc_next;
    logic [WIDTH-1:0]      w_mp_next;
    logic [c_STEP_W-1:0]   w_step_next;
    logic                  w_last;

    twos_magnitude #(.WIDTH(WIDTH)) u_mag_a (
        .value     (a),
        .is_signed (signed_in),
        .magnitude (w_mag_a)
    );

    twos_magnitude #(.WIDTH(WIDTH)) u_mag_b (
        .value     (b),
        .is_signed (signed_in),
        .magnitude (w_mag_b)
    );

    assign w_acc_next  = r_acc + (r_mp[0] ? r_mc : '0);
    assign w_mp_next   = r_mp >> 1;
    assign w_step_next = r_step + c_STEP_W'(1);
    // Early exit applies once no set multiplier bits remain to add.
    assign w_last      = (w_step_next == c_STEP_W'(WIDTH)) ||
                         ((EARLY_EXIT != 0) && (w_mp_next == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mp     <= '0;
            r_mc     <= '0;
            r_acc    <= '0;
            r_step   <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_mp    <= w_mag_a;
                        r_mc    <= {{WIDTH{1'b0}}, w_mag_b};
                        r_acc   <= '0;
                        r_step  <= '0;
                        r_neg   <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc  <= w_acc_next;
                    r_mp   <= w_mp_next;
                    r_mc   <= r_mc << 1;
                    r_step <= w_step_next;
                    if (w_last) begin
                        r_result <= r_neg ? -w_acc_next : w_acc_next;
                        r_valid  <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_out = (r_state == IDLE);
    assign valid_out = r_valid;
    assign r         = r_result;

endmodule

`default_nettype wire
